// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two combinational read ports, two prioritised
// write-back ports, optional write-to-read bypass and a per-register pending-write scoreboard.
module reg_file_mp #(
  parameter int   XLEN   = 32,
  parameter int   NREGS  = 32,
  parameter bit   BYPASS = 1'b1,
  localparam int  AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next-state: wb1 overrides wb0, issue overrides write-back clear; entry 0 stays zero.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (i == 0) begin
        mem_d[i]  = '0;
        busy_d[i] = 1'b0;
      end else begin
        if (wb1_valid && (wb1_addr == AW'(i))) begin
          mem_d[i] = wb1_data;
        end else if (wb0_valid && (wb0_addr == AW'(i))) begin
          mem_d[i] = wb0_data;
        end else begin
          mem_d[i] = mem_q[i];
        end
        if (iss_valid && (iss_addr == AW'(i))) begin
          busy_d[i] = 1'b1;
        end else if ((wb0_valid && (wb0_addr == AW'(i))) ||
                     (wb1_valid && (wb1_addr == AW'(i)))) begin
          busy_d[i] = 1'b0;
        end else begin
          busy_d[i] = busy_q[i];
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  logic [AW-1:0] rd_addr_s [2];
  assign rd_addr_s[0] = rs1_addr;
  assign rd_addr_s[1] = rs2_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [XLEN-1:0] data_s;
    logic            busy_s;
    logic            hit0_s;
    logic            hit1_s;
    logic            iss_hit_s;

    // Read mux: bypass forwards same-cycle write-back data and busy clears.
    always_comb begin
      hit0_s    = BYPASS && wb0_valid && (wb0_addr == rd_addr_s[p]);
      hit1_s    = BYPASS && wb1_valid && (wb1_addr == rd_addr_s[p]);
      iss_hit_s = iss_valid && (iss_addr == rd_addr_s[p]);
      if (!reset_n || (rd_addr_s[p] == '0)) begin
        data_s = '0;
        busy_s = 1'b0;
      end else begin
        if (hit1_s) begin
          data_s = wb1_data;
        end else if (hit0_s) begin
          data_s = wb0_data;
        end else begin
          data_s = mem_q[rd_addr_s[p]];
        end
        if ((hit0_s || hit1_s) && !iss_hit_s) begin
          busy_s = 1'b0;
        end else begin
          busy_s = busy_q[rd_addr_s[p]];
        end
      end
    end
  end

  assign rs1_data = g_rd[0].data_s;
  assign rs2_data = g_rd[1].data_s;
  assign rs1_busy = g_rd[0].busy_s;
  assign rs2_busy = g_rd[1].busy_s;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: three configurations (32x32 bypass, 32x32 no bypass,
// 64-bit x16 bypass) share one stimulus stream and are checked against an array model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rs1_addr, rs2_addr, iss_addr, wb0_addr, wb1_addr;
  logic        iss_valid, wb0_valid, wb1_valid;
  logic [31:0] wb0_data, wb1_data;

  logic [31:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
  logic [63:0] c_rs1_data, c_rs2_data;
  logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy, c_rs1_busy, c_rs2_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data)
  );

  reg_file_mp #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u_dut_nobyp (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data)
  );

  reg_file_mp #(.XLEN(64), .NREGS(16), .BYPASS(1'b1)) u_dut_wide (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(rs1_addr[3:0]), .rs2_addr(rs2_addr[3:0]),
    .rs1_data(c_rs1_data), .rs2_data(c_rs2_data),
    .rs1_busy(c_rs1_busy), .rs2_busy(c_rs2_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr[3:0]),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr[3:0]), .wb0_data({wb0_data, ~wb0_data}),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr[3:0]), .wb1_data({wb1_data, ~wb1_data})
  );

  // Reference model: per configuration an array of register values and busy flags.
  logic [63:0] m_mem  [3][32];
  logic        m_busy [3][32];

  typedef struct packed {
    logic [2:0][63:0] d1;
    logic [2:0][63:0] d2;
    logic [2:0]       b1;
    logic [2:0]       b2;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [4:0] amask(input int k);
    return (k == 2) ? 5'h0F : 5'h1F;
  endfunction

  function automatic logic [63:0] wdat(input int k, input logic [31:0] d);
    return (k == 2) ? {d, ~d} : {32'h0, d};
  endfunction

  task automatic model_read(input int k, input logic [4:0] ra, output logic [63:0] d,
                            output logic b);
    logic [4:0] a;
    logic w0, w1, is;
    a  = ra & amask(k);
    w0 = wb0_valid && ((wb0_addr & amask(k)) == a);
    w1 = wb1_valid && ((wb1_addr & amask(k)) == a);
    is = iss_valid && ((iss_addr & amask(k)) == a);
    if (!reset_n || a == 5'd0) begin
      d = 64'h0;
      b = 1'b0;
    end else begin
      d = m_mem[k][a];
      b = m_busy[k][a];
      if (k != 1) begin
        if (w1) d = wdat(k, wb1_data);
        else if (w0) d = wdat(k, wb0_data);
        if ((w0 || w1) && !is) b = 1'b0;
      end
    end
  endtask

  task automatic model_update();
    logic [4:0] a;
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        for (int r = 0; r < 32; r++) begin
          m_mem[k][r]  = 64'h0;
          m_busy[k][r] = 1'b0;
        end
      end else begin
        a = wb0_addr & amask(k);
        if (wb0_valid && a != 5'd0) begin
          m_mem[k][a] = wdat(k, wb0_data);
          m_busy[k][a] = 1'b0;
        end
        a = wb1_addr & amask(k);
        if (wb1_valid && a != 5'd0) begin
          m_mem[k][a] = wdat(k, wb1_data);
          m_busy[k][a] = 1'b0;
        end
        a = iss_addr & amask(k);
        if (iss_valid && a != 5'd0) m_busy[k][a] = 1'b1;
      end
    end
  endtask

  // Push the expectation for the current inputs, advance the model, move to the next cycle.
  task automatic step();
    exp_t e;
    logic [63:0] d;
    logic b;
    for (int k = 0; k < 3; k++) begin
      model_read(k, rs1_addr, d, b);
      e.d1[k] = d;
      e.b1[k] = b;
      model_read(k, rs2_addr, d, b);
      e.d2[k] = d;
      e.b2[k] = b;
    end
    exp_q.push_back(e);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset_n   = 1'b1;
    iss_valid = 1'b0;
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
  endtask

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result to compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [2:0][63:0] ad1, ad2;
      logic [2:0] ab1, ab2;
      e = exp_q.pop_front();
      ad1 = {c_rs1_data, {32'h0, b_rs1_data}, {32'h0, a_rs1_data}};
      ad2 = {c_rs2_data, {32'h0, b_rs2_data}, {32'h0, a_rs2_data}};
      ab1 = {c_rs1_busy, b_rs1_busy, a_rs1_busy};
      ab2 = {c_rs2_busy, b_rs2_busy, a_rs2_busy};
      for (int k = 0; k < 3; k++) begin
        chk("rs1_data", k, ad1[k], e.d1[k]);
        chk("rs2_data", k, ad2[k], e.d2[k]);
        chk("rs1_busy", k, {63'h0, ab1[k]}, {63'h0, e.b1[k]});
        chk("rs2_busy", k, {63'h0, ab2[k]}, {63'h0, e.b2[k]});
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 32; r++) begin
        m_mem[k][r]  = 64'h0;
        m_busy[k][r] = 1'b0;
      end
    idle();
    reset_n  = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; iss_addr = 5'd0; wb0_addr = 5'd0; wb1_addr = 5'd0;
    wb0_data = 32'h0; wb1_data = 32'h0;
    @(posedge clk);
    #1;
    step();
    step();

    // Reset clears a written register and forces outputs low while asserted.
    idle(); wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF; rs1_addr = 5'd5; step();
    idle(); reset_n = 1'b0; iss_valid = 1'b1; iss_addr = 5'd5; step();
    idle(); step();

    // x0 ignores writes and issues.
    idle(); wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'h12345678;
    iss_valid = 1'b1; iss_addr = 5'd0; rs1_addr = 5'd0; step();
    idle(); step();

    // Dual write-back collision on x7.
    idle(); wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'hAAAA0000;
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h0000BBBB; rs2_addr = 5'd7; step();
    idle(); rs1_addr = 5'd7; step();

    // Bypass visibility on x3.
    idle(); wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h00000042; rs1_addr = 5'd3; step();
    idle(); step();

    // Scoreboard: issue x9, write back on wb1 three cycles later.
    idle(); iss_valid = 1'b1; iss_addr = 5'd9; rs1_addr = 5'd9; step();
    idle(); step();
    step();
    wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h00000999; step();
    idle(); step();

    // Issue and write-back race on x4.
    idle(); iss_valid = 1'b1; iss_addr = 5'd4; wb0_valid = 1'b1; wb0_addr = 5'd4;
    wb0_data = 32'h00000099; rs1_addr = 5'd4; step();
    idle(); step();

    // Fill registers 1..15 with distinct patterns, then read everything back.
    for (int a = 1; a < 16; a++) begin
      idle(); wb0_valid = 1'b1; wb0_addr = 5'(a); wb0_data = $urandom; step();
    end
    for (int a = 0; a < 16; a++) begin
      idle(); rs1_addr = 5'(a); rs2_addr = 5'(a + 16); step();
    end

    // Random traffic with a narrow address range to provoke collisions.
    for (int n = 0; n < 1500; n++) begin
      reset_n   = ($urandom_range(0, 63) != 0);
      iss_valid = $urandom_range(0, 1) != 0;
      wb0_valid = $urandom_range(0, 1) != 0;
      wb1_valid = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 1) != 0) begin
        rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
        iss_addr = 5'($urandom_range(0, 7)); wb0_addr = 5'($urandom_range(0, 7));
        wb1_addr = 5'($urandom_range(0, 7));
      end else begin
        rs1_addr = 5'($urandom); rs2_addr = 5'($urandom); iss_addr = 5'($urandom);
        wb0_addr = 5'($urandom); wb1_addr = 5'($urandom);
      end
      wb0_data = $urandom;
      wb1_data = $urandom;
      step();
    end

    idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file with a pending-write scoreboard, the successor to the single-write-port core register file. It provides two combinational read ports, two write-back ports with a fixed priority, optional write-to-read bypass, and per-register busy bits. Issue sets a register's busy bit and write-back clears it, so decode can detect RAW hazards. It sits between decode/issue and the write-back stage of the core pipeline.

## Interface
- XLEN, 32, data width in bits (≥8).
- NREGS, 32, number of architectural registers (power of two, 2..64); register 0 is hard-wired zero.
- AW, $clog2(NREGS), address width (derived, not overridable).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array contents only.
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- rs1_addr, rs2_addr  input  AW each  read addresses.
- rs1_data, rs2_data  output  XLEN each  read data (combinational).
- rs1_busy, rs2_busy  output  1 each  scoreboard busy bit of the addressed register (combinational).
- iss_valid  input  1  issue of an instruction that will write iss_addr.
- iss_addr  input  AW  destination of the issued instruction.
- wb0_valid, wb1_valid  input  1 each  write-back strobes.
- wb0_addr, wb1_addr  input  AW each  write-back addresses.
- wb0_data, wb1_data  input  XLEN each  write-back data.

## Operation
- State: NREGS-1 data registers of XLEN bits, plus NREGS-1 busy bits. Register 0 has no storage.
- Register 0:
  - Reads always return 0 and busy=0.
  - Writes and issues to address 0 are ignored.
- Write, per rising edge with reset_n=1:
  - wbN_valid && wbN_addr≠0 writes wbN_data to the register.
  - If wb0 and wb1 both target the same nonzero address, wb1 wins; wb0's data is discarded.
- Busy, per rising edge with reset_n=1:
  - iss_valid && iss_addr≠0 sets busy[iss_addr].
  - A valid write-back to address a clears busy[a].
  - If issue and write-back target the same address in the same cycle, issue wins and busy stays 1. The write-back data is still written.
  - Two write-backs to one address clear it once; this is not an error.
- Read, combinational:
  - BYPASS=1: if a wb port is valid with address == rsN_addr ≠ 0, rsN_data is that port's data, with wb1 taking precedence over wb0. Otherwise rsN_data is the array contents.
  - BYPASS=1: rsN_busy reports 0 when a valid write-back to that address is present this cycle, and no same-address issue is present.
  - BYPASS=0: rsN_data and rsN_busy reflect the registered state only.
  - Issue never affects read data; it affects busy only from the next cycle.
- Reset (reset_n=0 at a rising edge):
  - All data registers and busy bits become 0, overriding any write, issue or write-back in that cycle.
  - While reset_n=0, rs1_data, rs2_data, rs1_busy and rs2_busy are forced to 0 and bypass is disabled.
- Addresses ≥ NREGS cannot occur, because AW is derived from NREGS.

## Timing
- Read latency: 0 cycles (combinational from rsN_addr and the current state).
- Write visibility:
  - BYPASS=1: visible the same cycle via bypass.
  - BYPASS=0: visible the cycle after the write edge.
- Busy set: visible one cycle after the iss_valid edge.
- Busy clear:
  - BYPASS=1: visible the same cycle as the wb strobe.
  - BYPASS=0: visible the next cycle.
- Reset: synchronous, takes effect at the first rising edge with reset_n=0. After release, the first edge with reset_n=1 performs normal updates.
- No handshakes. All inputs are sampled every edge and valid strobes are single-cycle qualifiers.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert reset_n=0 for one edge, release. Required: rs1_addr=5 gives rs1_data=0, rs1_busy=0; outputs read 0 while reset_n=0.
- x0: wb0 writes 0x12345678 to x0 and issue targets x0. Required: next cycle rs1_addr=0 gives data 0, busy 0.
- Dual write collision: wb0 writes 0xAAAA0000 and wb1 writes 0x0000BBBB to x7 in one cycle. Required: x7=0x0000BBBB afterwards; with BYPASS=1, rs2_data is 0x0000BBBB in the same cycle.
- Bypass modes: write 0x00000042 to x3 with rs1_addr=3. Required: rs1_data=0x42 in the same cycle with BYPASS=1; with BYPASS=0, old value that cycle and 0x42 the next.
- Scoreboard: issue x9 at cycle n → rs1_busy=1 from n+1. At wb1 to x9 in cycle n+3 → busy=0 in n+3 (BYPASS=1) or n+4 (BYPASS=0).
- Issue/write-back race: issue x4 and wb0 to x4 with 0x99 in the same cycle. Required: next cycle busy[4]=1 and rs1_data=0x99. Additionally, parametrised run with XLEN=64, NREGS=16: write all 15 registers, read back patterns, check no aliasing.
